fifo_stream_reader: RTL and testbench

//  Read-side master for the library's synchronous FIFOs. Drains a FIFO with a 1-cycle registered read port:

---
 rtl/fifo_stream_pkg.sv | 19 +
 rtl/fifo_skid_buf.sv | 68 ++++++
 rtl/fifo_stream_reader.sv | 77 +++++++
 tb/tb_fifo_stream_reader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared constants and width helpers for the FIFO stream blocks.
// Reused by reader and future writer-side adapters.
package fifo_stream_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_SKID_DEPTH = 4;
   localparam int DEF_CNT_WIDTH  = 16;

   // Width able to hold a count 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width able to index entries 0..depth-1.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Skid register array with head/tail/occupancy.
// Push/pop/clear ports; output is zero while empty.
module fifo_skid_buf
   import fifo_stream_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_SKID_DEPTH,
   localparam int OW         = occ_width(DEPTH),
   localparam int PW         = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [OW-1:0]         o_occ,
   output logic [DATA_WIDTH-1:0] o_data
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [OW-1:0] FULL = OW'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_head;
   logic [PW-1:0]         r_tail;
   logic [OW-1:0]         r_occ;
   logic                  w_pop;
   logic [PW-1:0]         w_head_nxt;
   logic [PW-1:0]         w_tail_nxt;

   assign w_pop      = i_pop & (r_occ != '0);
   assign w_head_nxt = (r_head == LAST) ? '0 : r_head + PW'(1);
   assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + PW'(1);

   // Pointer and occupancy bookkeeping; clear wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else if (i_clear) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         if (i_push) r_tail <= w_tail_nxt;
         if (w_pop)  r_head <= w_head_nxt;
         case ({i_push, w_pop})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Data storage needs no reset: it is masked while empty.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_tail] <= i_push_data;
   end

   assign o_occ  = r_occ;
   assign o_data = (r_occ != '0) ? r_mem[r_head] : '0;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(i_push && !i_clear && !w_pop && r_occ == FULL));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream via a skid buffer.
// FIFO_STREAM_READER_CNT_EN enables the delivered-word counter on word_cnt.
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SKID_DEPTH = DEF_SKID_DEPTH,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   localparam int OW = occ_width(SKID_DEPTH);
   localparam logic [OW:0] LIMIT = SKID_DEPTH[OW:0];

   logic          r_inflight;
   logic [OW-1:0] w_occ;
   logic [OW:0]   w_sum;
   logic          w_rd_en;
   logic          w_push;
   logic          w_pop;

   // Reserve a skid slot for every word still on its way back.
   assign w_sum   = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight};
   assign w_rd_en = rst_n & enable & ~flush & ~fifo_empty
                  & (w_sum < LIMIT);
   assign w_push  = r_inflight & ~flush;
   assign w_pop   = m_valid & m_ready;

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = (w_occ != '0);

   // Track the word returning on the FIFO read port next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_inflight <= 1'b0;
      else        r_inflight <= w_rd_en;
   end

   fifo_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (SKID_DEPTH)
   ) u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (flush),
      .i_push      (w_push),
      .i_push_data (fifo_rd_data),
      .i_pop       (w_pop),
      .o_occ       (w_occ),
      .o_data      (m_data)
   );

`ifdef FIFO_STREAM_READER_CNT_EN
   logic [CNT_WIDTH-1:0] r_word_cnt;

   // Count stream handshakes; flush leaves the count alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_word_cnt <= '0;
      else if (w_pop) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
   end

   assign word_cnt = r_word_cnt;
`else
   assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: depth 4 and depth 2 instances.
// Each DUT is fed by a small registered-read FIFO model.
module tb_fifo_stream_reader;

`ifdef FIFO_STREAM_READER_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0, flush = 1'b0, m_ready = 1'b0;
   logic        fifo_empty, fifo_rd_en, m_valid;
   logic [7:0]  fifo_rd_data = '0, m_data;
   logic [15:0] word_cnt;

   logic        enable2 = 1'b0, flush2 = 1'b0, m_ready2 = 1'b0;
   logic        fifo_empty2, fifo_rd_en2, m_valid2;
   logic [7:0]  fifo_rd_data2 = '0, m_data2;
   logic [15:0] word_cnt2;

   logic [7:0]  f1_mem [0:4095];
   int          f1_wr = 0, f1_rd = 0;
   logic        f1_clr = 1'b0;
   logic [7:0]  f2_mem [0:255];
   int          f2_wr = 0, f2_rd = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(8), .SKID_DEPTH(4), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .word_cnt(word_cnt));

   fifo_stream_reader #(.DATA_WIDTH(8), .SKID_DEPTH(2), .CNT_WIDTH(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(enable2), .flush(flush2),
      .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2),
      .fifo_rd_data(fifo_rd_data2), .m_valid(m_valid2), .m_ready(m_ready2),
      .m_data(m_data2), .word_cnt(word_cnt2));

   assign fifo_empty  = (f1_rd == f1_wr);
   assign fifo_empty2 = (f2_rd == f2_wr);

   always @(posedge clk) begin
      if (f1_clr) begin
         f1_rd <= f1_wr;
         fifo_rd_data <= '0;
      end else if (fifo_rd_en && !fifo_empty) begin
         fifo_rd_data <= f1_mem[f1_rd];
         f1_rd <= f1_rd + 1;
      end else begin
         fifo_rd_data <= '0;
      end
   end

   always @(posedge clk) begin
      if (fifo_rd_en2 && !fifo_empty2) begin
         fifo_rd_data2 <= f2_mem[f2_rd];
         f2_rd <= f2_rd + 1;
      end else begin
         fifo_rd_data2 <= '0;
      end
   end

   task automatic test_reset();
      f1_mem[f1_wr] = 8'h5A; f1_wr++;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_data, word_cnt} !== 26'd0) begin
         errors++;
         $display("FAIL reset: rd_en=%b valid=%b data=%h cnt=%0d want all 0",
                  fifo_rd_en, m_valid, m_data, word_cnt);
      end
      f1_clr = 1'b1;
      @(negedge clk);
      f1_clr = 1'b0; enable = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic       er, ev;
      logic [7:0] ed;
      @(negedge clk);
      for (int i = 1; i <= 3; i++) begin
         f1_mem[f1_wr] = 8'(8'hA0 + i); f1_wr++;
      end
      enable = 1'b1; m_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         er = (c < 3);
         ev = (c >= 2 && c <= 4);
         ed = ev ? 8'(8'hA0 + c - 1) : 8'h00;
         checks++;
         if ({fifo_rd_en, m_valid, m_data} !== {er, ev, ed}) begin
            errors++;
            $display("FAIL basic c%0d: rd_en=%b valid=%b data=%h want %b %b %h",
                     c, fifo_rd_en, m_valid, m_data, er, ev, ed);
         end
      end
      checks++;
      if (word_cnt !== (CNT_ON ? 16'd3 : 16'd0)) begin
         errors++;
         $display("FAIL basic_cnt: got %0d want %0d", word_cnt, CNT_ON ? 3 : 0);
      end
      enable = 1'b0;
   endtask

   task automatic test_backpressure();
      int pulses = 0;
      int got = 0;
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         f1_mem[f1_wr] = 8'(8'h10 + i); f1_wr++;
      end
      enable = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (fifo_rd_en) pulses++;
         if (c >= 2) begin
            checks++;
            if ({m_valid, m_data} !== {1'b1, 8'h10}) begin
               errors++;
               $display("FAIL bp_hold c%0d: valid=%b data=%h want 1 10",
                        c, m_valid, m_data);
            end
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL bp_pulses: got %0d want 4", pulses);
      end
      m_ready = 1'b1;
      for (int c = 0; c < 40 && got < 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (m_valid) begin
            checks++;
            if (m_data !== 8'(8'h10 + got)) begin
               errors++;
               $display("FAIL bp_drain w%0d: got %h want %h",
                        got, m_data, 8'(8'h10 + got));
            end
            got++;
         end
      end
      checks++;
      if (got != 10) begin
         errors++;
         $display("FAIL bp_drain_count: got %0d want 10", got);
      end
      enable = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_depth2();
      int got = 0;
      int last = 0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         f2_mem[f2_wr] = 8'(8'hC0 + i); f2_wr++;
      end
      enable2 = 1'b1; m_ready2 = 1'b1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (m_valid2) begin
            checks++;
            if (m_data2 !== 8'(8'hC0 + got)) begin
               errors++;
               $display("FAIL d2_order w%0d: got %h want %h",
                        got, m_data2, 8'(8'hC0 + got));
            end
            got++;
            last = c;
         end
      end
      checks++;
      if (got != 8 || last > 16) begin
         errors++;
         $display("FAIL d2_rate: words=%0d last_cycle=%0d want 8 by 16",
                  got, last);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid2, word_cnt2} !== {1'b0, (CNT_ON ? 16'd8 : 16'd0)}) begin
         errors++;
         $display("FAIL d2_end: valid=%b cnt=%0d want 0 %0d",
                  m_valid2, word_cnt2, CNT_ON ? 8 : 0);
      end
      enable2 = 1'b0;
   endtask

   task automatic test_flush();
      logic [10:0] exp [9];
      exp[0] = {1'b1, 1'b0, 8'h00, 1'b0};
      exp[1] = {1'b1, 1'b0, 8'h00, 1'b0};
      exp[2] = {1'b1, 1'b1, 8'hD0, 1'b0};
      exp[3] = {1'b0, 1'b1, 8'hD0, 1'b1};
      exp[4] = {1'b1, 1'b0, 8'h00, 1'b0};
      exp[5] = {1'b1, 1'b0, 8'h00, 1'b0};
      exp[6] = {1'b0, 1'b1, 8'hD3, 1'b0};
      exp[7] = {1'b0, 1'b1, 8'hD4, 1'b0};
      exp[8] = {1'b0, 1'b0, 8'h00, 1'b0};
      @(negedge clk);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         f1_mem[f1_wr] = 8'(8'hD0 + i); f1_wr++;
      end
      enable = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         flush = exp[c][0];
         m_ready = (c >= 6);
         #1;
         checks++;
         if ({fifo_rd_en, m_valid, m_data} !== exp[c][10:1]) begin
            errors++;
            $display("FAIL flush c%0d: rd_en=%b valid=%b data=%h want %b %b %h",
                     c, fifo_rd_en, m_valid, m_data,
                     exp[c][10], exp[c][9], exp[c][8:1]);
         end
      end
      flush = 1'b0;
      enable = 1'b0;
   endtask

   task automatic test_enable_drop();
      logic [9:0] exp [5];
      exp[0] = {1'b1, 1'b0, 8'h00};
      exp[1] = {1'b0, 1'b0, 8'h00};
      exp[2] = {1'b0, 1'b1, 8'hE0};
      exp[3] = {1'b0, 1'b0, 8'h00};
      exp[4] = {1'b0, 1'b0, 8'h00};
      @(negedge clk);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f1_mem[f1_wr] = 8'(8'hE0 + i); f1_wr++;
      end
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         enable = (c == 0);
         #1;
         checks++;
         if ({fifo_rd_en, m_valid, m_data} !== exp[c]) begin
            errors++;
            $display("FAIL en_drop c%0d: rd_en=%b valid=%b data=%h want %b %b %h",
                     c, fifo_rd_en, m_valid, m_data,
                     exp[c][9], exp[c][8], exp[c][7:0]);
         end
      end
      f1_clr = 1'b1;
      @(negedge clk);
      f1_clr = 1'b0;
   endtask

   task automatic test_random_reset();
      int base, idx;
      @(negedge clk);
      base = f1_wr;
      idx = base;
      for (int i = 0; i < 1000; i++) begin
         f1_mem[f1_wr] = 8'($urandom_range(0, 255)); f1_wr++;
      end
      enable = 1'b1;
      for (int c = 0; c < 600; c++) begin
         if (c > 0) @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         #1;
         if (m_valid && m_ready) begin
            checks++;
            if (m_data !== f1_mem[idx]) begin
               errors++;
               $display("FAIL rand w%0d: got %h want %h",
                        idx - base, m_data, f1_mem[idx]);
            end
            idx++;
         end
      end
      checks++;
      if (idx - base < 100) begin
         errors++;
         $display("FAIL rand_progress: got %0d words want >=100", idx - base);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_data, word_cnt, word_cnt2} !== 42'd0) begin
         errors++;
         $display("FAIL rand_reset: rd_en=%b valid=%b data=%h cnt=%0d cnt2=%0d want 0",
                  fifo_rd_en, m_valid, m_data, word_cnt, word_cnt2);
      end
      f1_clr = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      f1_clr = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_data, word_cnt} !== 26'd0) begin
         errors++;
         $display("FAIL post_reset: rd_en=%b valid=%b data=%h cnt=%0d want 0",
                  fifo_rd_en, m_valid, m_data, word_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_depth2();
      test_flush();
      test_enable_drop();
      test_random_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout at %0t want completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
